// File: rtl/receptor_quadro_serial_if.sv
// receptor_quadro_serial_if: serial line in, payload/frame status out, for the frame receiver.
interface receptor_quadro_serial_if;
  logic       entrada_serial;
  logic [7:0] dado;
  logic       dado_valido;
  logic [7:0] indice;
  logic       quadro_ok;
  logic       quadro_erro;
  logic       erro_enquadramento;
  logic [3:0] db_estado;
  modport master (
    output entrada_serial,
    input  dado, dado_valido, indice, quadro_ok, quadro_erro, erro_enquadramento, db_estado
  );
  modport slave (
    input  entrada_serial,
    output dado, dado_valido, indice, quadro_ok, quadro_erro, erro_enquadramento, db_estado
  );
endinterface

// File: rtl/receptor_quadro_serial.sv
// receptor_quadro_serial: 8N1 UART deserialiser plus sync/length/payload frame parser.
// Define RECEPTOR_CHECKSUM_EN to require a trailing XOR checksum byte per frame.
module receptor_quadro_serial #(
  parameter int         CICLOS_POR_BIT = 434,
  parameter int         MAX_BYTES      = 16,
  parameter logic [7:0] BYTE_SYNC      = 8'hA5
) (
  input logic                     clock,
  input logic                     reset,
  receptor_quadro_serial_if.slave link
);
  localparam int CW = $clog2(CICLOS_POR_BIT);
  typedef enum logic [1:0] {OCIOSO, INICIO, DADOS, PARADA} bit_t;
  typedef enum logic [1:0] {ESPERA_SYNC, LE_TAMANHO, LE_DADOS, LE_CHECKSUM} quadro_t;
  logic [1:0] sinc_q;
  bit_t bit_q, bit_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] nbit_q, nbit_d;
  logic [7:0] shift_q, shift_d;
  logic rx, meio, cheio, byte_v, ferr;
  quadro_t est_q, est_d;
  logic [7:0] len_q, len_d, idx_q, idx_d, acc_q, acc_d, dado_q, dado_d, ind_q, ind_d;
  logic dv_q, dv_d, ok_q, ok_d, err_q, err_d, fe_q, fe_d;
  assign rx    = sinc_q[1];
  assign meio  = cnt_q == CW'(CICLOS_POR_BIT / 2 - 1);
  assign cheio = cnt_q == CW'(CICLOS_POR_BIT - 1);
  always_comb begin
    bit_d   = bit_q;
    cnt_d   = cnt_q + 1'b1;
    nbit_d  = nbit_q;
    shift_d = shift_q;
    byte_v  = 1'b0;
    ferr    = 1'b0;
    case (bit_q)
      OCIOSO: begin
        cnt_d = '0;
        bit_d = rx ? OCIOSO : INICIO;
      end
      INICIO: if (meio) begin
        cnt_d  = '0;
        nbit_d = '0;
        bit_d  = rx ? OCIOSO : DADOS;
      end
      DADOS: if (cheio) begin
        cnt_d   = '0;
        shift_d = {rx, shift_q[7:1]};
        nbit_d  = nbit_q + 1'b1;
        bit_d   = nbit_q == 3'd7 ? PARADA : DADOS;
      end
      PARADA: if (cheio) begin
        byte_v = rx;
        ferr   = !rx;
        bit_d  = OCIOSO;
      end
    endcase
  end
  // shift_q holds the completed byte while the stop bit is being sampled
  always_comb begin
    est_d  = est_q;
    len_d  = len_q;
    idx_d  = idx_q;
    acc_d  = acc_q;
    dado_d = dado_q;
    ind_d  = ind_q;
    dv_d   = 1'b0;
    ok_d   = 1'b0;
    err_d  = 1'b0;
    fe_d   = ferr;
    if (ferr) begin
      err_d = est_q != ESPERA_SYNC;
      est_d = ESPERA_SYNC;
    end else if (byte_v) begin
      case (est_q)
        ESPERA_SYNC: est_d = shift_q == BYTE_SYNC ? LE_TAMANHO : ESPERA_SYNC;
        LE_TAMANHO: begin
          len_d = shift_q;
          idx_d = '0;
          acc_d = shift_q;
          if (shift_q > 8'(MAX_BYTES)) begin
            err_d = 1'b1;
            est_d = ESPERA_SYNC;
          end else if (shift_q == 8'd0) begin
`ifdef RECEPTOR_CHECKSUM_EN
            est_d = LE_CHECKSUM;
`else
            ok_d  = 1'b1;
            est_d = ESPERA_SYNC;
`endif
          end else est_d = LE_DADOS;
        end
        LE_DADOS: begin
          dado_d = shift_q;
          ind_d  = idx_q;
          dv_d   = 1'b1;
          acc_d  = acc_q ^ shift_q;
          idx_d  = idx_q + 8'd1;
          if (idx_q == len_q - 8'd1) begin
`ifdef RECEPTOR_CHECKSUM_EN
            est_d = LE_CHECKSUM;
`else
            ok_d  = 1'b1;
            est_d = ESPERA_SYNC;
`endif
          end
        end
        LE_CHECKSUM: begin
          ok_d  = shift_q == acc_q;
          err_d = shift_q != acc_q;
          est_d = ESPERA_SYNC;
        end
      endcase
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      sinc_q  <= 2'b11;
      bit_q   <= OCIOSO;
      cnt_q   <= '0;
      nbit_q  <= '0;
      shift_q <= '0;
      est_q   <= ESPERA_SYNC;
      len_q   <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      dado_q  <= '0;
      ind_q   <= '0;
      dv_q    <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      sinc_q  <= {sinc_q[0], link.entrada_serial};
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
      nbit_q  <= nbit_d;
      shift_q <= shift_d;
      est_q   <= est_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      dado_q  <= dado_d;
      ind_q   <= ind_d;
      dv_q    <= dv_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      fe_q    <= fe_d;
    end
  end
  assign link.dado               = dado_q;
  assign link.indice             = ind_q;
  assign link.dado_valido        = dv_q;
  assign link.quadro_ok          = ok_q;
  assign link.quadro_erro        = err_q;
  assign link.erro_enquadramento = fe_q;
  assign link.db_estado          = {2'b00, est_q};
endmodule

// File: tb/tb_receptor_quadro_serial.sv
// tb_receptor_quadro_serial: random and directed frames checked every cycle against a byte-stream model.
module tb_receptor_quadro_serial;
  localparam int CPB = 8;
  localparam int OFF = 3 + CPB / 2 + 9 * CPB;
`ifdef RECEPTOR_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif
  logic clock = 1'b0;
  logic reset = 1'b1;
  receptor_quadro_serial_if link ();
  receptor_quadro_serial #(.CICLOS_POR_BIT(CPB), .MAX_BYTES(16), .BYTE_SYNC(8'hA5)) dut (
    .clock(clock), .reset(reset), .link(link)
  );
  always #5 clock = ~clock;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;
  typedef struct {
    int t;
    logic dv, ok, err, fe;
    logic [3:0] st;
    logic [7:0] d, i;
  } ev_t;
  ev_t evq[$];
  int errors = 0, checks = 0;
  int n_dv = 0, n_ok = 0, n_err = 0, n_fe = 0;
  int s_dv, s_ok, s_err, s_fe;
  bit m_act = 1'b0;
  logic [7:0] frm[$];
  logic [7:0] m_d = 8'h00, m_i = 8'h00;

  // Frame model: bytes since the sync marker live in frm; frm[0] is the length.
  task automatic model_byte(input logic [7:0] b, input bit stop, input int t);
    ev_t e;
    int n;
    logic [7:0] x;
    e.t = t; e.dv = 1'b0; e.ok = 1'b0; e.err = 1'b0; e.fe = !stop;
    if (!stop) begin
      e.err = m_act;
      m_act = 1'b0;
    end else if (!m_act) begin
      m_act = b == 8'hA5;
      frm.delete();
    end else begin
      frm.push_back(b);
      n = int'(frm[0]);
      if (frm.size() == 1) begin
        if (n > 16) begin e.err = 1'b1; m_act = 1'b0; end
        else if (n == 0 && !CK) begin e.ok = 1'b1; m_act = 1'b0; end
      end else if (frm.size() <= n + 1) begin
        e.dv = 1'b1;
        m_d = b;
        m_i = 8'(frm.size() - 2);
        if (frm.size() == n + 1 && !CK) begin e.ok = 1'b1; m_act = 1'b0; end
      end else begin
        x = 8'h00;
        for (int k = 0; k <= n; k++) x ^= frm[k];
        e.ok = b == x;
        e.err = b != x;
        m_act = 1'b0;
      end
    end
    e.st = !m_act ? 4'd0 : frm.size() == 0 ? 4'd1 : frm.size() <= int'(frm[0]) ? 4'd2 : 4'd3;
    e.d = m_d;
    e.i = m_i;
    evq.push_back(e);
  endtask

  initial begin : compare
    ev_t ce;
    logic [3:0] h_st;
    logic [7:0] h_d, h_i;
    logic [23:0] act, exp;
    h_st = 4'd0; h_d = 8'h00; h_i = 8'h00;
    forever begin
      @(negedge clock);
      if (reset) begin
        h_st = 4'd0; h_d = 8'h00; h_i = 8'h00;
        evq.delete();
      end else begin
        if (evq.size() > 0 && evq[0].t == cyc) begin
          ce = evq.pop_front();
          h_st = ce.st; h_d = ce.d; h_i = ce.i;
          exp = {ce.dv, ce.ok, ce.err, ce.fe, h_st, h_d, h_i};
        end else exp = {4'b0000, h_st, h_d, h_i};
        act = {link.dado_valido, link.quadro_ok, link.quadro_erro, link.erro_enquadramento,
               link.db_estado, link.dado, link.indice};
        checks++;
        if (act !== exp) begin
          errors++;
          $display("FAIL cycle %0d outputs {dv,ok,err,fe,st,dado,idx}: got %h expected %h", cyc, act, exp);
        end
        n_dv += int'(link.dado_valido);
        n_ok += int'(link.quadro_ok);
        n_err += int'(link.quadro_erro);
        n_fe += int'(link.erro_enquadramento);
      end
    end
  end

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, want);
    end
  endtask

  task automatic snap();
    s_dv = n_dv; s_ok = n_ok; s_err = n_err; s_fe = n_fe;
  endtask

  task automatic deltas(input string nm, input int dv, input int ok, input int err, input int fe);
    chk({nm, " dado_valido count"}, n_dv - s_dv, dv);
    chk({nm, " quadro_ok count"}, n_ok - s_ok, ok);
    chk({nm, " quadro_erro count"}, n_err - s_err, err);
    chk({nm, " erro_enquadramento count"}, n_fe - s_fe, fe);
    chk({nm, " db_estado"}, int'(link.db_estado), 0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1 reset = 1'b1;
    link.entrada_serial = 1'b1;
    frm.delete();
    m_act = 1'b0; m_d = 8'h00; m_i = 8'h00;
    @(posedge clock);
    #1 reset = 1'b0;
  endtask

  // Returns on the edge ending the stop bit so the next call starts with zero idle.
  task automatic send_byte(input logic [7:0] b, input bit stop);
    @(posedge clock);
    #1 model_byte(b, stop, cyc + OFF);
    link.entrada_serial = 1'b0;
    for (int k = 0; k < 9; k++) begin
      repeat (CPB) @(posedge clock);
      #1 link.entrada_serial = k < 8 ? b[k] : stop;
    end
    if (!stop) begin
      repeat (CPB) @(posedge clock);
      #1 link.entrada_serial = 1'b1;
      repeat (3 * CPB) @(posedge clock);
    end else repeat (CPB - 1) @(posedge clock);
  endtask

  task automatic send_list(input logic [7:0] bs[$]);
    foreach (bs[k]) send_byte(bs[k], 1'b1);
  endtask

  initial begin : main
    logic [7:0] b, x;
    int len;
    link.entrada_serial = 1'b1;
    do_reset();
    idle(3);
    chk("reset dado", int'(link.dado), 0);
    chk("reset indice", int'(link.indice), 0);
    chk("reset db_estado", int'(link.db_estado), 0);
    chk("reset pulses", int'({link.dado_valido, link.quadro_ok, link.quadro_erro, link.erro_enquadramento}), 0);

    snap();
    send_list('{8'hA5, 8'h02, 8'h3C, 8'h5A, 8'h64});
    idle(4);
    deltas("good frame", 2, 1, 0, 0);
    chk("good frame last dado", int'(link.dado), 8'h5A);
    chk("good frame last indice", int'(link.indice), 1);

    snap();
    send_list('{8'hA5, 8'h02, 8'h3C, 8'h5A, 8'h65});
    idle(4);
    deltas("bad checksum", 2, CK ? 0 : 1, CK ? 1 : 0, 0);

    snap();
    @(posedge clock);
    #1 link.entrada_serial = 1'b0;
    idle(3);
    #1 link.entrada_serial = 1'b1;
    idle(20);
    deltas("glitch", 0, 0, 0, 0);
    send_list('{8'hA5, 8'h02, 8'h3C, 8'h5A, 8'h64});
    idle(4);
    deltas("glitch then frame", 2, 1, 0, 0);

    snap();
    send_list('{8'hA5, 8'h02, 8'h3C});
    send_byte(8'h5A, 1'b0);
    send_list('{8'h12, 8'h34});
    idle(4);
    deltas("framing error", 1, 0, 1, 1);

    snap();
    send_list('{8'hA5, 8'h20});
    idle(4);
    deltas("length too big", 0, 0, 1, 0);
    snap();
    send_list('{8'hA5, 8'h00, 8'h00});
    idle(4);
    deltas("empty frame", 0, 1, 0, 0);

    send_list('{8'hA5, 8'h03, 8'h11});
    @(posedge clock);
    #1 link.entrada_serial = 1'b0;
    idle(3 * CPB);
    do_reset();
    idle(4);
    chk("mid-frame reset db_estado", int'(link.db_estado), 0);
    chk("mid-frame reset dado", int'(link.dado), 0);
    snap();
    send_list('{8'hA5, 8'h01, 8'hFF, 8'hFE});
    idle(4);
    deltas("after reset", 1, 1, 0, 0);
    chk("after reset dado", int'(link.dado), 8'hFF);
    chk("after reset indice", int'(link.indice), 0);

    for (int f = 0; f < 40; f++) begin
      repeat ($urandom_range(0, 2)) begin
        b = 8'($urandom_range(0, 255));
        send_byte(b == 8'hA5 ? 8'h00 : b, $urandom_range(0, 19) != 0);
      end
      send_byte(8'hA5, 1'b1);
      len = $urandom_range(0, 18);
      x = 8'(len);
      send_byte(8'(len), $urandom_range(0, 19) != 0);
      for (int k = 0; k < len; k++) begin
        b = 8'($urandom_range(0, 255));
        x ^= b;
        send_byte(b, $urandom_range(0, 29) != 0);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 5));
      end
      send_byte($urandom_range(0, 3) != 0 ? x : 8'($urandom_range(0, 255)), $urandom_range(0, 19) != 0);
      idle($urandom_range(0, 6));
    end
    idle(2 * OFF);
    chk("event queue drained", evq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
